// File: rtl/mips_gpio_port.sv
// Memory-mapped GPIO for the single-cycle MIPS core: OUT latch, debounced IN,
// sticky rising-edge capture (W1C) and a masked level interrupt.
module mips_gpio_port #(
   parameter logic [31:0] BASE_ADDR       = 32'h1001_0040,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Hit,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        IRQ
);

   typedef enum logic [0:0] {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } db_state_t;

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [31:0] out_r;
   logic [7:0]  edge_r;
   logic        irq_en_r;
   logic [7:0]  edge_mask_r;
   logic        irq_r;
   logic [7:0]  sync1_r;
   logic [7:0]  sync2_r;
   logic [7:0]  debounced_r;
   logic [7:0]  sample_r;
   logic [15:0] cnt_r;
   db_state_t   state_r;

   logic        hit_s;
   logic        wr_s;
   logic [1:0]  offset_s;
   logic        load_s;
   logic [7:0]  edge_rise_s;
   logic [7:0]  edge_clr_s;
   logic [31:0] rdata_s;
   logic        unused_s;

   assign hit_s    = (Address[31:4] == BASE_ADDR[31:4]);
   assign wr_s     = MemWrite & hit_s;
   assign offset_s = Address[3:2];
   assign unused_s = ^Address[1:0];

   // Debounced value is loaded once the sample held steady through the last count
   always_comb begin
      load_s = 1'b0;
      if (state_r == ST_COUNTING) begin
         load_s = (sync2_r != debounced_r) && (sync2_r == sample_r) && (cnt_r == CNT_LAST);
      end else if (DEBOUNCE_CYCLES == 1) begin
         load_s = (sync2_r != debounced_r);
      end else begin
         load_s = 1'b0;
      end
   end

   // Rising edges of the debounced inputs and W1C clear strobes
   always_comb begin
      edge_rise_s = 8'h00;
      edge_clr_s  = 8'h00;
      if (load_s) begin
         edge_rise_s = sync2_r & ~debounced_r;
      end else begin
         edge_rise_s = 8'h00;
      end
      if (wr_s && (offset_s == 2'd2)) begin
         edge_clr_s = WriteData[7:0];
      end else begin
         edge_clr_s = 8'h00;
      end
   end

   // Two-flop synchronizer on the raw switch inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 8'h00;
         sync2_r <= 8'h00;
      end else begin
         sync1_r <= PortIn;
         sync2_r <= sync1_r;
      end
   end

   // Shared debounce FSM: any change restarts the count with the new sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_STABLE;
         cnt_r       <= 16'd0;
         sample_r    <= 8'h00;
         debounced_r <= 8'h00;
      end else begin
         case (state_r)
            ST_STABLE: begin
               if (sync2_r != debounced_r) begin
                  if (load_s) begin
                     debounced_r <= sync2_r;
                  end else begin
                     state_r  <= ST_COUNTING;
                     cnt_r    <= 16'd1;
                     sample_r <= sync2_r;
                  end
               end
            end
            ST_COUNTING: begin
               if (sync2_r == debounced_r) begin
                  state_r <= ST_STABLE;
                  cnt_r   <= 16'd0;
               end else if (sync2_r != sample_r) begin
                  cnt_r    <= 16'd1;
                  sample_r <= sync2_r;
               end else if (load_s) begin
                  debounced_r <= sync2_r;
                  state_r     <= ST_STABLE;
                  cnt_r       <= 16'd0;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
               state_r <= ST_STABLE;
               cnt_r   <= 16'd0;
            end
         endcase
      end
   end

   // Bus-writable registers; a set on EDGE wins over a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_r       <= 32'h0000_0000;
         edge_r      <= 8'h00;
         irq_en_r    <= 1'b0;
         edge_mask_r <= 8'h00;
         irq_r       <= 1'b0;
      end else begin
         if (wr_s && (offset_s == 2'd0)) begin
            out_r <= WriteData;
         end
         if (wr_s && (offset_s == 2'd3)) begin
            irq_en_r    <= WriteData[0];
            edge_mask_r <= WriteData[15:8];
         end
         edge_r <= (edge_r & ~edge_clr_s) | edge_rise_s;
         irq_r  <= irq_en_r & (|(edge_r & edge_mask_r));
      end
   end

   // Zero-latency read mux for the single-cycle core
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (MemRead && hit_s) begin
         case (offset_s)
            2'd0:    rdata_s = out_r;
            2'd1:    rdata_s = {24'h00_0000, debounced_r};
            2'd2:    rdata_s = {24'h00_0000, edge_r};
            2'd3:    rdata_s = {16'h0000, edge_mask_r, 7'h00, irq_en_r};
            default: rdata_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   assign ReadData = rdata_s;
   assign Hit      = hit_s;
   assign PortOut  = out_r;
   assign IRQ      = irq_r;

endmodule
